// File: rtl/unidade_controle_jogo.sv
// Control unit for the memory game: a Moore FSM that sequences the datapath counters,
// the play register and the inactivity timer, and reports how the game ended.
module unidade_controle_jogo (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic       jogada_feita,
    input  logic       jogada_igual,
    input  logic       fim_rodada,
    input  logic       fim_jogo,
    input  logic       inativo,
    output logic       zera_jogada,
    output logic       conta_jogada,
    output logic       zera_rodada,
    output logic       conta_rodada,
    output logic       zeraR,
    output logic       registraR,
    output logic       zeraInativo,
    output logic       contaInativo,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       timeout,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIA_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMA_JOGADA = 4'h6,
        PROXIMA_RODADA = 4'h7,
        FIM_ACERTOU    = 4'hA,
        FIM_TIMEOUT    = 4'hD,
        FIM_ERROU      = 4'hE
    } estado_t;

    estado_t estado_q, estado_d;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIAL;
        end else begin
            estado_q <= estado_d;
        end
    end

    // jogada_feita is a single-cycle pulse; it is sampled only in ESPERA_JOGADA
    // and takes priority over the inactivity timeout in that same cycle.
    always_comb begin
        estado_d = estado_q;
        unique case (estado_q)
            INICIAL:        estado_d = iniciar ? PREPARACAO : INICIAL;
            PREPARACAO:     estado_d = INICIA_RODADA;
            INICIA_RODADA:  estado_d = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (jogada_feita)   estado_d = REGISTRA;
                else if (inativo)   estado_d = FIM_TIMEOUT;
                else                estado_d = ESPERA_JOGADA;
            end
            REGISTRA:       estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!jogada_igual)               estado_d = FIM_ERROU;
                else if (fim_rodada && fim_jogo) estado_d = FIM_ACERTOU;
                else if (fim_rodada)             estado_d = PROXIMA_RODADA;
                else                             estado_d = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA: estado_d = ESPERA_JOGADA;
            PROXIMA_RODADA: estado_d = INICIA_RODADA;
            FIM_ACERTOU,
            FIM_TIMEOUT,
            FIM_ERROU:      estado_d = iniciar ? PREPARACAO : estado_q;
            default:        estado_d = INICIAL;
        endcase
    end

    always_comb begin
        zera_jogada  = 1'b0;
        conta_jogada = 1'b0;
        zera_rodada  = 1'b0;
        conta_rodada = 1'b0;
        zeraR        = 1'b0;
        registraR    = 1'b0;
        zeraInativo  = 1'b0;
        contaInativo = 1'b0;
        pronto       = 1'b0;
        acertou      = 1'b0;
        errou        = 1'b0;
        timeout      = 1'b0;
        case (estado_q)
            PREPARACAO: begin
                zera_jogada = 1'b1;
                zera_rodada = 1'b1;
                zeraR       = 1'b1;
                zeraInativo = 1'b1;
            end
            INICIA_RODADA: begin
                zera_jogada = 1'b1;
                zeraInativo = 1'b1;
            end
            ESPERA_JOGADA:  contaInativo = 1'b1;
            REGISTRA: begin
                registraR   = 1'b1;
                zeraInativo = 1'b1;
            end
            PROXIMA_JOGADA: conta_jogada = 1'b1;
            PROXIMA_RODADA: conta_rodada = 1'b1;
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
            end
            default: ;
        endcase
    end

    assign db_estado = estado_q;

endmodule

// File: tb/tb_unidade_controle_jogo.sv
// Directed bench for the game control FSM: walks start, rounds, error, timeout,
// win, restart and asynchronous reset, checking state code and all outputs.
module tb_unidade_controle_jogo;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       jogada_feita;
    logic       jogada_igual;
    logic       fim_rodada;
    logic       fim_jogo;
    logic       inativo;
    logic       zera_jogada;
    logic       conta_jogada;
    logic       zera_rodada;
    logic       conta_rodada;
    logic       zeraR;
    logic       registraR;
    logic       zeraInativo;
    logic       contaInativo;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    int n_cmp = 0;
    int n_err = 0;

    // Output vector order:
    // zera_jogada conta_jogada zera_rodada conta_rodada zeraR registraR
    // zeraInativo contaInativo pronto acertou errou timeout
    localparam logic [11:0] O_NONE = 12'h000;
    localparam logic [11:0] O_PREP = 12'hAA0;
    localparam logic [11:0] O_INIR = 12'h820;
    localparam logic [11:0] O_ESPE = 12'h010;
    localparam logic [11:0] O_REGI = 12'h060;
    localparam logic [11:0] O_PJOG = 12'h400;
    localparam logic [11:0] O_PROD = 12'h100;
    localparam logic [11:0] O_FACE = 12'h00C;
    localparam logic [11:0] O_FERR = 12'h00A;
    localparam logic [11:0] O_FTMO = 12'h009;

    wire [11:0] outs = {zera_jogada, conta_jogada, zera_rodada, conta_rodada, zeraR, registraR,
                        zeraInativo, contaInativo, pronto, acertou, errou, timeout};

    unidade_controle_jogo dut (
        .clock        (clock),
        .reset        (reset),
        .iniciar      (iniciar),
        .jogada_feita (jogada_feita),
        .jogada_igual (jogada_igual),
        .fim_rodada   (fim_rodada),
        .fim_jogo     (fim_jogo),
        .inativo      (inativo),
        .zera_jogada  (zera_jogada),
        .conta_jogada (conta_jogada),
        .zera_rodada  (zera_rodada),
        .conta_rodada (conta_rodada),
        .zeraR        (zeraR),
        .registraR    (registraR),
        .zeraInativo  (zeraInativo),
        .contaInativo (contaInativo),
        .pronto       (pronto),
        .acertou      (acertou),
        .errou        (errou),
        .timeout      (timeout),
        .db_estado    (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [3:0] exp_st, input logic [11:0] exp_o);
        n_cmp++;
        assert (db_estado === exp_st) else begin
            n_err++;
            $error("FAIL %s state: observed %h expected %h", tag, db_estado, exp_st);
        end
        n_cmp++;
        assert (outs === exp_o) else begin
            n_err++;
            $error("FAIL %s outputs: observed %h expected %h", tag, outs, exp_o);
        end
    endtask

    task automatic restart_to_espera(input string tag);
        iniciar = 1'b1;
        step(); check({tag, "_s1"}, 4'h1, O_PREP);
        iniciar = 1'b0;
        step(); check({tag, "_s2"}, 4'h2, O_INIR);
        step(); check({tag, "_s3"}, 4'h3, O_ESPE);
    endtask

    initial begin
        reset = 1'b0; iniciar = 1'b0; jogada_feita = 1'b0; jogada_igual = 1'b0;
        fim_rodada = 1'b0; fim_jogo = 1'b0; inativo = 1'b0;
        #3;
        check("reset", 4'h0, O_NONE);
        step(); step();
        reset = 1'b1;
        step(); check("idle_after_reset", 4'h0, O_NONE);
        step(); check("idle_hold", 4'h0, O_NONE);

        restart_to_espera("start");
        step(); check("espera_hold", 4'h3, O_ESPE);
        iniciar = 1'b1;
        step(); check("iniciar_ignored", 4'h3, O_ESPE);
        iniciar = 1'b0;

        // First round completes correctly.
        jogada_feita = 1'b1; jogada_igual = 1'b1; fim_rodada = 1'b1; fim_jogo = 1'b0;
        step(); check("r1_registra", 4'h4, O_REGI);
        jogada_feita = 1'b0;
        step(); check("r1_compara", 4'h5, O_NONE);
        step(); check("r1_prox_rodada", 4'h7, O_PROD);
        step(); check("r1_inicia", 4'h2, O_INIR);
        step(); check("r1_espera", 4'h3, O_ESPE);

        // Mid-round play.
        fim_rodada = 1'b0;
        jogada_feita = 1'b1;
        step(); check("mid_registra", 4'h4, O_REGI);
        jogada_feita = 1'b0;
        step(); check("mid_compara", 4'h5, O_NONE);
        step(); check("mid_prox_jogada", 4'h6, O_PJOG);
        step(); check("mid_espera", 4'h3, O_ESPE);

        // Play and timeout together: play wins; then a wrong play.
        jogada_feita = 1'b1; inativo = 1'b1;
        step(); check("tie_registra", 4'h4, O_REGI);
        jogada_feita = 1'b0; inativo = 1'b0;
        step(); check("err_compara", 4'h5, O_NONE);
        jogada_igual = 1'b0;
        step(); check("err_fim", 4'hE, O_FERR);
        step(); check("err_hold", 4'hE, O_FERR);
        jogada_igual = 1'b1;

        restart_to_espera("after_err");
        inativo = 1'b1;
        step(); check("tmo_fim", 4'hD, O_FTMO);
        inativo = 1'b0;
        step(); check("tmo_hold", 4'hD, O_FTMO);

        restart_to_espera("after_tmo");
        jogada_feita = 1'b1; jogada_igual = 1'b1; fim_rodada = 1'b1; fim_jogo = 1'b1;
        step(); check("win_registra", 4'h4, O_REGI);
        jogada_feita = 1'b0;
        step(); check("win_compara", 4'h5, O_NONE);
        step(); check("win_fim", 4'hA, O_FACE);
        step(); check("win_hold", 4'hA, O_FACE);

        restart_to_espera("after_win");
        fim_rodada = 1'b0; fim_jogo = 1'b0;
        jogada_feita = 1'b1;
        step(); check("ar_registra", 4'h4, O_REGI);
        jogada_feita = 1'b0;
        step(); check("ar_compara", 4'h5, O_NONE);
        step(); check("ar_prox_jogada", 4'h6, O_PJOG);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_now", 4'h0, O_NONE);
        step(); check("async_reset_held", 4'h0, O_NONE);
        reset = 1'b1;
        step(); check("post_reset_idle", 4'h0, O_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
